warp_scheduler: RTL

WARP_SCHEDULER -- requirements
Module: warp_scheduler

---
 rtl/Structs_and_Params.sv | 23 ++
 rtl/kernel_fifo.sv | 58 +++++
 rtl/warp_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/Structs_and_Params.sv
// Shared kernel/launch types and scheduler state encoding used by the SIMD front end.
package Structs_and_Params;

    localparam int unsigned THREAD_COUNT        = 16;
    localparam int unsigned PC_W                = 32;
    localparam int unsigned WARP_ID_W           = 4;
    localparam int unsigned DEFAULT_QUEUE_DEPTH = 4;

    typedef logic [THREAD_COUNT-1:0] thread_mask_t;

    typedef struct packed {
        logic [PC_W-1:0]      start_pc;
        logic [WARP_ID_W-1:0] warp_id;
    } kernel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        RUN      = 2'd2,
        RETIRE   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/kernel_fifo.sv
// Launch queue: power-of-two FIFO of kernel_t with wrap-around pointers and occupancy count.
module kernel_fifo
    import Structs_and_Params::*;
#(
    parameter int unsigned DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  kernel_t                push_data_i,
    input  logic                   pop_i,
    output kernel_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    kernel_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Payload storage carries no reset; only entries behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Queues kernel launches and hands them one at a time to simd_core, retiring each on
// a matching completion or a RUN-state watchdog expiry.
module warp_scheduler
    import Structs_and_Params::*;
#(
    parameter int unsigned QUEUE_DEPTH    = DEFAULT_QUEUE_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         launch_valid,
    input  kernel_t                      launch_kernel,
    output logic                         launch_ready,
    output kernel_t                      core_kernel,
    output logic                         core_start,
    input  logic                         core_is_finished,
    input  logic [3:0]                   core_finished_warp_id,
    output logic                         done_valid,
    output logic [3:0]                   done_warp_id,
    output logic                         done_timeout,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    sched_state_t    state_q, state_d;
    kernel_t         core_kernel_q, core_kernel_d;
    logic            core_start_q, core_start_d;
    logic            done_valid_q, done_valid_d;
    logic [3:0]      done_warp_id_q, done_warp_id_d;
    logic            done_timeout_q, done_timeout_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;
    kernel_t         fifo_head;
    logic            dispatch_go;
    logic            id_match;

    assign fifo_push    = launch_valid && !fifo_full;
    assign launch_ready = !fifo_full;
    assign busy         = (state_q != IDLE) || !fifo_empty;

    kernel_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (launch_kernel),
        .pop_i       (dispatch_go),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (queue_count)
    );

    // The head is popped on the edge that enters DISPATCH, so core_start and core_kernel
    // are already valid throughout the DISPATCH cycle.
    assign dispatch_go = ((state_q == IDLE) || (state_q == RETIRE)) && !fifo_empty;
    assign id_match    = core_is_finished && (core_finished_warp_id == core_kernel_q.warp_id);

    always_comb begin
        state_d        = state_q;
        core_kernel_d  = core_kernel_q;
        core_start_d   = 1'b0;
        done_valid_d   = 1'b0;
        done_warp_id_d = done_warp_id_q;
        done_timeout_d = done_timeout_q;
        wdog_d         = wdog_q;

        case (state_q)
            IDLE, RETIRE: begin
                state_d = dispatch_go ? DISPATCH : IDLE;
            end
            DISPATCH: begin
                state_d = RUN;
            end
            RUN: begin
                // A genuine completion wins over a watchdog expiry in the same cycle.
                if (id_match) begin
                    state_d        = RETIRE;
                    done_valid_d   = 1'b1;
                    done_warp_id_d = core_kernel_q.warp_id;
                    done_timeout_d = 1'b0;
                end else if (wdog_q == WD_LAST) begin
                    state_d        = RETIRE;
                    done_valid_d   = 1'b1;
                    done_warp_id_d = core_kernel_q.warp_id;
                    done_timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (dispatch_go) begin
            core_kernel_d = fifo_head;
            core_start_d  = 1'b1;
            wdog_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            core_kernel_q  <= '0;
            core_start_q   <= 1'b0;
            done_valid_q   <= 1'b0;
            done_warp_id_q <= '0;
            done_timeout_q <= 1'b0;
            wdog_q         <= '0;
        end else begin
            state_q        <= state_d;
            core_kernel_q  <= core_kernel_d;
            core_start_q   <= core_start_d;
            done_valid_q   <= done_valid_d;
            done_warp_id_q <= done_warp_id_d;
            done_timeout_q <= done_timeout_d;
            wdog_q         <= wdog_d;
        end
    end

    assign core_kernel  = core_kernel_q;
    assign core_start   = core_start_q;
    assign done_valid   = done_valid_q;
    assign done_warp_id = done_warp_id_q;
    assign done_timeout = done_timeout_q;

endmodule
